// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: assembles little-endian words from a
// byte stream, writes them from address 0 and releases the core when done.
module imem_loader #(
    parameter int         ADDR_W   = 8,
    parameter logic [6:0] HALT_OPC = 7'b1111111
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              core_enable,
    output logic              done,
    output logic              full,
    output logic [ADDR_W:0]   word_count
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WRITE,
        DONE
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          bc_q, bc_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W:0]     wc_q, wc_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                full_q, full_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bc_q    <= '0;
            idx_q   <= '0;
            wc_q    <= '0;
            wdata_q <= '0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bc_q    <= bc_d;
            idx_q   <= idx_d;
            wc_q    <= wc_d;
            wdata_q <= wdata_d;
            full_q  <= full_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bc_d    = bc_q;
        idx_d   = idx_q;
        wc_d    = wc_q;
        wdata_d = wdata_q;
        full_d  = full_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    bc_d    = '0;
                    idx_d   = '0;
                    wc_d    = '0;
                    full_d  = 1'b0;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    unique case (bc_q)
                        2'd0: wdata_d[7:0]   = in_data;
                        2'd1: wdata_d[15:8]  = in_data;
                        2'd2: wdata_d[23:16] = in_data;
                        2'd3: wdata_d[31:24] = in_data;
                        default: ;
                    endcase
                    bc_d = bc_q + 2'd1;
                    if (bc_q == 2'd3) begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                idx_d = idx_q + ADDR_W'(1);
                wc_d  = wc_q + (ADDR_W + 1)'(1);
                if (wdata_q[6:0] == HALT_OPC) begin
                    state_d = DONE;
                end else if (&idx_q) begin
                    // Last slot written without a halt word.
                    state_d = DONE;
                    full_d  = 1'b1;
                end else begin
                    state_d = LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready    = (state_q == LOAD);
    assign imem_we     = (state_q == WRITE);
    assign imem_addr   = idx_q;
    assign imem_wdata  = wdata_q;
    assign core_rst    = (state_q != DONE);
    assign core_enable = (state_q == DONE);
    assign done        = (state_q == DONE);
    assign full        = full_q;
    assign word_count  = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader (ADDR_W=2): expected writes are queued
// as bytes are driven and popped when the loader strobes imem_we.
module tb_imem_loader;

    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          core_enable;
    logic          done;
    logic          full;
    logic [AW:0]   word_count;

    int checks = 0;
    int errors = 0;
    logic mon_load = 1'b0;

    logic [31:0] exp_data[$];
    int          exp_addr[$];
    logic [31:0] prog[$];

    imem_loader #(.ADDR_W(AW)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .in_data(in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .imem_we(imem_we),
        .imem_addr(imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst(core_rst),
        .core_enable(core_enable),
        .done(done),
        .full(full),
        .word_count(word_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we) begin
            chk("rdy_in_write", 32'(in_ready), 32'd0);
            if (exp_data.size() == 0) begin
                chk("we_extra", 32'(imem_we), 32'd0);
            end else begin
                chk("waddr", 32'(imem_addr), 32'(exp_addr.pop_front()));
                chk("wdata", imem_wdata, exp_data.pop_front());
            end
        end else if (mon_load && !done) begin
            chk("rdy_in_load", 32'(in_ready), 32'd1);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("byte_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
    endtask

    task automatic wait_done(input int exp_wc, input logic exp_full);
        int n;
        in_valid = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        mon_load = 1'b0;
        chk("done", 32'(done), 32'd1);
        chk("core_rst", 32'(core_rst), 32'd0);
        chk("core_en", 32'(core_enable), 32'd1);
        chk("full", 32'(full), 32'(exp_full));
        chk("wcount", 32'(word_count), 32'(exp_wc));
        chk("sb_empty", 32'(exp_data.size()), 32'd0);
    endtask

    // Drives prog[] after a start pulse; start_at >= 0 pulses start again
    // just before that byte index to show it is ignored mid-load.
    task automatic run_prog(input int maxgap, input int start_at);
        int   nw;
        logic xf;
        nw = 0;
        xf = 1'b0;
        foreach (prog[i]) begin
            if (nw < (1 << AW) && (i == 0 || prog[i-1][6:0] != 7'h7F)) begin
                exp_addr.push_back(i);
                exp_data.push_back(prog[i]);
                nw++;
            end
        end
        if (nw == (1 << AW) && prog[nw-1][6:0] != 7'h7F) xf = 1'b1;
        pulse_start();
        mon_load = 1'b1;
        chk("rdy_after_start", 32'(in_ready), 32'd1);
        chk("crst_loading", 32'(core_rst), 32'd1);
        for (int w = 0; w < nw; w++) begin
            for (int j = 0; j < 4; j++) begin
                if (w * 4 + j == start_at) begin
                    in_valid = 1'b0;
                    pulse_start();
                end
                send_byte(prog[w][8*j +: 8], $urandom_range(0, maxgap));
            end
        end
        wait_done(nw, xf);
    endtask

    task automatic basic_prog();
        prog = '{32'h00500093, 32'h00A00113, 32'h0000007F};
    endtask

    initial begin
        #12;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we", 32'(imem_we), 32'd0);
        chk("rst_addr", 32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_crst", 32'(core_rst), 32'd1);
        chk("rst_cen", 32'(core_enable), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_wc", 32'(word_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        basic_prog();
        run_prog(0, -1);

        pulse_start();
        chk("rl_crst", 32'(core_rst), 32'd1);
        chk("rl_cen", 32'(core_enable), 32'd0);
        chk("rl_done", 32'(done), 32'd0);
        chk("rl_full", 32'(full), 32'd0);
        chk("rl_wc", 32'(word_count), 32'd0);
        chk("rl_ready", 32'(in_ready), 32'd1);
        prog = '{32'h00000013, 32'hFFFFFFFF};
        exp_addr.push_back(0);
        exp_data.push_back(prog[0]);
        exp_addr.push_back(1);
        exp_data.push_back(prog[1]);
        mon_load = 1'b1;
        for (int k = 0; k < 8; k++) send_byte(prog[k/4][8*(k%4) +: 8], 0);
        wait_done(2, 1'b0);

        basic_prog();
        run_prog(3, -1);

        basic_prog();
        run_prog(1, 6);

        prog = '{32'h00000013, 32'h00000013, 32'h00000013, 32'h00000013};
        run_prog(2, -1);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("byte17_ready", 32'(in_ready), 32'd0);
        end
        chk("byte17_wc", 32'(word_count), 32'd4);
        in_valid = 1'b0;

        basic_prog();
        exp_addr.push_back(0);
        exp_data.push_back(prog[0]);
        pulse_start();
        mon_load = 1'b1;
        for (int k = 0; k < 6; k++) send_byte(prog[k/4][8*(k%4) +: 8], 0);
        mon_load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mr_ready", 32'(in_ready), 32'd0);
        chk("mr_we", 32'(imem_we), 32'd0);
        chk("mr_addr", 32'(imem_addr), 32'd0);
        chk("mr_wdata", imem_wdata, 32'd0);
        chk("mr_crst", 32'(core_rst), 32'd1);
        chk("mr_cen", 32'(core_enable), 32'd0);
        chk("mr_done", 32'(done), 32'd0);
        chk("mr_wc", 32'(word_count), 32'd0);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("mr_idle_ready", 32'(in_ready), 32'd0);
        chk("mr_sb", 32'(exp_data.size()), 32'd0);
        run_prog(0, -1);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
